// File: rtl/run_sequencer.sv
// run_sequencer: loads a host image into data memory, runs the core until done or timeout,
// then streams a result window from data memory back to the host.
module run_sequencer #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int LOAD_BASE = 0,
   parameter int LOAD_LEN  = 64,
   parameter int UL_BASE   = 64,
   parameter int UL_LEN    = 8,
   parameter int TIMEOUT   = 4095
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          start,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [DW-1:0] ld_data,
   output logic          core_reset,
   input  logic          core_done,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdat,
   output logic          mem_wen,
   output logic          mem_ren,
   input  logic [DW-1:0] mem_rdat,
   output logic          mem_own,
   output logic          ul_valid,
   input  logic          ul_ready,
   output logic [DW-1:0] ul_data,
   output logic          busy,
   output logic          finished,
   output logic          timed_out,
   output logic [15:0]   run_cycles
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, UL_RD, UL_WAIT, FINISH} state_t;
   state_t state;
   logic [AW-1:0] idx;
   assign ld_ready = state == LOAD;
   assign mem_wen  = ld_ready && ld_valid;
   assign mem_wdat = ld_data;
   assign mem_addr = (state == UL_RD ? AW'(UL_BASE) : AW'(LOAD_BASE)) + idx;
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         idx        <= '0;
         core_reset <= 1'b1;
         mem_own    <= 1'b1;
         mem_ren    <= 1'b0;
         ul_valid   <= 1'b0;
         ul_data    <= '0;
         busy       <= 1'b0;
         finished   <= 1'b0;
         timed_out  <= 1'b0;
         run_cycles <= '0;
      end else begin
         case (state)
            IDLE, FINISH: if (start) begin
               state      <= LOAD;
               idx        <= '0;
               run_cycles <= '0;
               timed_out  <= 1'b0;
               finished   <= 1'b0;
               busy       <= 1'b1;
            end
            LOAD: if (ld_valid) begin
               idx <= idx + 1'b1;
               if (idx == AW'(LOAD_LEN - 1)) begin
                  state      <= RUN;
                  idx        <= '0;
                  core_reset <= 1'b0;
                  mem_own    <= 1'b0;
               end
            end
            RUN: begin
               run_cycles <= &run_cycles ? run_cycles : run_cycles + 16'd1;
               // done and timeout on the same cycle is reported as done
               if (core_done || run_cycles == 16'(TIMEOUT - 1)) begin
                  state      <= UL_RD;
                  timed_out  <= !core_done;
                  core_reset <= 1'b1;
                  mem_own    <= 1'b1;
                  mem_ren    <= 1'b1;
                  idx        <= '0;
               end
            end
            UL_RD: begin
               mem_ren <= 1'b0;
               state   <= UL_WAIT;
            end
            UL_WAIT: if (!ul_valid) begin
               ul_data  <= mem_rdat;
               ul_valid <= 1'b1;
            end else if (ul_ready) begin
               ul_valid <= 1'b0;
               idx      <= idx + 1'b1;
               if (idx == AW'(UL_LEN - 1)) begin
                  state    <= FINISH;
                  finished <= 1'b1;
               end else begin
                  state   <= UL_RD;
                  mem_ren <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed bench for run_sequencer with default and wrapping-address instances.
module tb_run_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_a, start_a, ldv_a, ldr_a, crst_a, done_a, wen_a, ren_a, own_a, ulv_a, ulr_a, busy_a, fin_a, to_a;
   logic [7:0] ldd_a, addr_a, wdat_a, rdat_a, uld_a;
   logic [15:0] rc_a;
   logic rst_b, start_b, ldv_b, ldr_b, crst_b, done_b, wen_b, ren_b, own_b, ulv_b, ulr_b, busy_b, fin_b, to_b;
   logic [7:0] ldd_b, addr_b, wdat_b, rdat_b, uld_b;
   logic [15:0] rc_b;
   logic clr_a, clr_b;
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   int wcnt_a;
   int checks = 0, failures = 0;
   run_sequencer u0 (
      .Clk(clk), .Reset(rst_a), .start(start_a), .ld_valid(ldv_a), .ld_ready(ldr_a), .ld_data(ldd_a),
      .core_reset(crst_a), .core_done(done_a), .mem_addr(addr_a), .mem_wdat(wdat_a), .mem_wen(wen_a),
      .mem_ren(ren_a), .mem_rdat(rdat_a), .mem_own(own_a), .ul_valid(ulv_a), .ul_ready(ulr_a),
      .ul_data(uld_a), .busy(busy_a), .finished(fin_a), .timed_out(to_a), .run_cycles(rc_a)
   );
   run_sequencer #(.LOAD_BASE(250), .LOAD_LEN(10), .UL_BASE(254), .UL_LEN(3), .TIMEOUT(20)) u1 (
      .Clk(clk), .Reset(rst_b), .start(start_b), .ld_valid(ldv_b), .ld_ready(ldr_b), .ld_data(ldd_b),
      .core_reset(crst_b), .core_done(done_b), .mem_addr(addr_b), .mem_wdat(wdat_b), .mem_wen(wen_b),
      .mem_ren(ren_b), .mem_rdat(rdat_b), .mem_own(own_b), .ul_valid(ulv_b), .ul_ready(ulr_b),
      .ul_data(uld_b), .busy(busy_b), .finished(fin_b), .timed_out(to_b), .run_cycles(rc_b)
   );
   // synchronous-read data memories; clear zeroes the load area and seeds the result window
   always @(posedge clk) begin
      if (clr_a) begin
         wcnt_a <= 0;
         for (int k = 0; k < 256; k++) mem_a[k] <= k >= 64 ? 8'(k + 96) : 8'h00;
      end else if (wen_a) begin
         mem_a[addr_a] <= wdat_a;
         wcnt_a <= wcnt_a + 1;
      end
      if (ren_a) rdat_a <= mem_a[addr_a];
   end
   always @(posedge clk) begin
      if (clr_b) begin
         for (int k = 0; k < 256; k++) mem_b[k] <= 8'h00;
      end else if (wen_b) mem_b[addr_b] <= wdat_b;
      if (ren_b) rdat_b <= mem_b[addr_b];
   end
   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       ready;
      logic       wen;
      logic [7:0] addr;
   } vec_t;
   vec_t vecs [127];
   logic [7:0] wrap_addr [10];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic int img_err_a();
      int e = 0;
      for (int i = 0; i < 64; i++) if (mem_a[i] !== 8'(i)) e++;
      return e;
   endfunction
   task automatic unload_a(input int stall_at);
      for (int k = 0; k < 8; k++) begin
         int w = 0;
         while (!ulv_a && w < 10) begin
            tick();
            w++;
         end
         chk("ul_valid_wait", ulv_a, 1);
         chk("ul_data", uld_a, 8'(8'hA0 + k));
         if (k == stall_at) begin
            for (int s = 0; s < 5; s++) begin
               tick();
               chk("stall_hold", {ulv_a, ren_a, uld_a}, {1'b1, 1'b0, 8'(8'hA0 + k)});
            end
         end
         ulr_a = 1'b1;
         tick();
         ulr_a = 1'b0;
         if (k < 7) chk("ul_next_rd", {ren_a, addr_a}, {1'b1, 8'(65 + k)});
      end
      chk("finish_state", {fin_a, crst_a, busy_a, own_a, ulv_a}, 5'b11110);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int j = 0; j < 127; j++) begin
         vecs[j].valid = (j % 2) == 0;
         vecs[j].data  = 8'(j / 2);
         vecs[j].ready = 1'b1;
         vecs[j].wen   = (j % 2) == 0;
         vecs[j].addr  = (j % 2) == 0 ? 8'(j / 2) : 8'h00;
      end
      wrap_addr = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3};
      {rst_a, start_a, ldv_a, ldd_a, done_a, ulr_a} = '0;
      {rst_b, start_b, ldv_b, ldd_b, done_b, ulr_b} = '0;
      clr_a = 1'b1;
      clr_b = 1'b1;
      tick();
      tick();
      clr_a = 1'b0;
      clr_b = 1'b0;
      chk("rst_flags", {crst_a, own_a, busy_a, fin_a, ldr_a, ulv_a, ren_a, wen_a, to_a}, 9'b110000000);
      chk("rst_values", {rc_a, uld_a}, 0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick();
      chk("idle_after_rst", {busy_a, ldr_a, crst_a}, 3'b001);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("load_entry", {ldr_a, busy_a, crst_a, own_a}, 4'hF);
      for (int i = 0; i < 64; i++) begin
         ldv_a = 1'b1;
         ldd_a = 8'(i);
         #1;
         chk("load_wr", {ldr_a, wen_a, addr_a, wdat_a}, {1'b1, 1'b1, 8'(i), 8'(i)});
         tick();
      end
      chk("run_entry", {crst_a, own_a, ldr_a, wen_a, busy_a}, 5'b00001);
      ldv_a = 1'b0;
      chk("load_count", wcnt_a, 64);
      chk("load_image", img_err_a(), 0);
      repeat (99) tick();
      chk("run_mid", {rc_a, crst_a}, {16'd99, 1'b0});
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      chk("done_exit", {crst_a, own_a, ren_a, to_a, addr_a}, {4'b1110, 8'd64});
      chk("run_cycles_done", rc_a, 100);
      unload_a(-1);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("finish_holds", {fin_a, busy_a}, 2'b11);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("restart", {fin_a, to_a, rc_a, ldr_a}, {2'b00, 16'd0, 1'b1});
      for (int j = 0; j < 127; j++) begin
         ldv_a = vecs[j].valid;
         ldd_a = vecs[j].data;
         #1;
         chk("toggle_wr", {ldr_a, wen_a, wen_a ? addr_a : 8'h00}, {vecs[j].ready, vecs[j].wen, vecs[j].addr});
         tick();
      end
      ldv_a = 1'b0;
      chk("toggle_count", wcnt_a, 64);
      chk("toggle_image", img_err_a(), 0);
      chk("toggle_run", {crst_a, own_a}, 2'b00);
      begin
         int w = 0;
         while (!ren_a && w < 5000) begin
            tick();
            w++;
         end
         chk("timeout_cycles", w, 4095);
      end
      chk("timeout_flag", {to_a, rc_a, crst_a, addr_a}, {1'b1, 16'd4095, 1'b1, 8'd64});
      unload_a(3);
      chk("timeout_sticky", to_a, 1);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ldv_a = 1'b1;
         ldd_a = 8'(i);
         tick();
      end
      #3;
      rst_a = 1'b0;
      #1;
      chk("async_rst", {crst_a, own_a, busy_a, ldr_a, wen_a, fin_a, to_a, rc_a}, {7'b1100000, 16'd0});
      tick();
      rst_a = 1'b1;
      tick();
      chk("idle_ignores_load", {ldr_a, wen_a}, 2'b00);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ldd_a = 8'(i);
         #1;
         if (i == 0) chk("reload_base", {wen_a, addr_a}, {1'b1, 8'd0});
         tick();
      end
      ldv_a = 1'b0;
      chk("reload_image", img_err_a(), 0);
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      chk("done_first_cycle", {rc_a, to_a, ren_a}, {16'd1, 1'b0, 1'b1});
      unload_a(-1);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ldv_b = 1'b1;
         ldd_b = 8'(8'h10 + i);
         #1;
         chk("wrap_wr", {wen_b, addr_b}, {1'b1, wrap_addr[i]});
         tick();
      end
      ldv_b = 1'b0;
      chk("wrap_run", {crst_b, own_b}, 2'b00);
      repeat (19) tick();
      chk("tie_pre", rc_b, 19);
      done_b = 1'b1;
      tick();
      done_b = 1'b0;
      chk("tie_done_wins", {to_b, rc_b, ren_b, addr_b}, {1'b0, 16'd20, 1'b1, 8'd254});
      for (int k = 0; k < 3; k++) begin
         int w = 0;
         while (!ulv_b && w < 10) begin
            tick();
            w++;
         end
         chk("wrap_ul", {ulv_b, uld_b}, {1'b1, 8'(8'h14 + k)});
         ulr_b = 1'b1;
         tick();
         ulr_b = 1'b0;
      end
      chk("wrap_finish", {fin_b, crst_b}, 2'b11);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
